// File: rtl/mul_arb_pkg.sv
// Shared FP16 field layout and normalize helper for the shared-multiplier arbiter.
package mul_arb_pkg;

   localparam int unsigned FP_W      = 16;
   localparam int unsigned EXP_W     = 5;
   localparam int unsigned MAN_W     = 10;
   localparam int unsigned BIAS      = 15;
   localparam int unsigned PROD_W    = 2 * (MAN_W + 1);
   localparam int unsigned PROD_HI_W = MAN_W + 2;

   typedef struct packed {
      logic             sign;
      logic [EXP_W-1:0] expo;
      logic [MAN_W-1:0] mant;
   } fp16_t;

   // Width of an index into n items, at least one bit.
   function automatic int unsigned id_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // mhi holds product bits [21:10]; a set MSB means the significand product is in [2,4).
   function automatic fp16_t fp16_norm(input logic             sign,
                                       input logic [EXP_W-1:0] esum,
                                       input logic [PROD_HI_W-1:0] mhi);
      fp16_t r;
      r.sign = sign;
      if (mhi[PROD_HI_W-1]) begin
         r.expo = esum + EXP_W'(1);
         r.mant = mhi[PROD_HI_W-2:1];
      end else begin
         r.expo = esum;
         r.mant = mhi[MAN_W-1:0];
      end
      return r;
   endfunction

endpackage

// File: rtl/mul_share_arb_if.sv
// Requester operand bus and tagged result bus of the shared FP16 multiplier.
interface mul_share_arb_if #(parameter int unsigned NUM_REQ = 4) ();
   import mul_arb_pkg::*;

   localparam int unsigned ID_W = id_width(NUM_REQ);

   logic [NUM_REQ-1:0]      req_valid;
   logic [NUM_REQ-1:0]      req_ready;
   logic [NUM_REQ*FP_W-1:0] req_a;
   logic [NUM_REQ*FP_W-1:0] req_b;
   logic                    rsp_valid;
   logic                    rsp_ready;
   logic [ID_W-1:0]         rsp_id;
   logic [FP_W-1:0]         rsp_data;

   modport master (
      output req_valid, req_a, req_b, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_data
   );

   modport slave (
      input  req_valid, req_a, req_b, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_data
   );

endinterface

// File: rtl/mul_arb_rr_pick.sv
// Round-robin picker: first set request at or after ptr, wrapping modulo N.
module mul_arb_rr_pick #(
   parameter int unsigned N     = 4,
   parameter int unsigned IDX_W = 2
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     grant_c,
   output logic [IDX_W-1:0] idx_c,
   output logic             any_c
);

   logic [IDX_W-1:0] cand;

   always_comb begin
      grant_c = '0;
      idx_c   = '0;
      any_c   = 1'b0;
      cand    = '0;
      for (int unsigned k = 0; k < N; k++) begin
         cand = IDX_W'((32'(ptr) + k) % N);
         if (!any_c && req[cand]) begin
            grant_c[cand] = 1'b1;
            idx_c         = cand;
            any_c         = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mul_share_arb.sv
// One pipelined FP16 multiplier shared round-robin by NUM_REQ requesters, results via credited FIFO.
// Optional stall counter port enabled by defining MUL_ARB_STALL_CNT_EN.
module mul_share_arb
   import mul_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst_n,
`ifdef MUL_ARB_STALL_CNT_EN
   output logic [15:0] stall_cnt,
`endif
   mul_share_arb_if.slave bus
);

   localparam int unsigned ID_W  = id_width(NUM_REQ);
   localparam int unsigned PTR_W = id_width(FIFO_DEPTH);
   localparam int unsigned CRD_W = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned ENT_W = ID_W + FP_W;

   logic [ID_W-1:0]    ptr;
   logic [CRD_W-1:0]   credits;
   logic [NUM_REQ-1:0] elig_c;
   logic [NUM_REQ-1:0] grant_c;
   logic [ID_W-1:0]    gidx_c;
   logic               issue_c;
   logic               push_c;
   logic               pop_c;
   fp16_t              op_a_c;
   fp16_t              op_b_c;
   logic [MAN_W:0]     man_a_c;
   logic [MAN_W:0]     man_b_c;

   // Credits gate eligibility so nothing issues that the FIFO could not absorb.
   assign elig_c = bus.req_valid & {NUM_REQ{credits != '0}};

   mul_arb_rr_pick #(.N(NUM_REQ), .IDX_W(ID_W)) u_pick (
      .req     (elig_c),
      .ptr     (ptr),
      .grant_c (grant_c),
      .idx_c   (gidx_c),
      .any_c   (issue_c)
   );

   assign bus.req_ready = grant_c;

   always_comb begin
      op_a_c = '0;
      op_b_c = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         if (grant_c[k]) begin
            op_a_c = bus.req_a[k*FP_W +: FP_W];
            op_b_c = bus.req_b[k*FP_W +: FP_W];
         end
      end
   end

   assign man_a_c = {1'b1, op_a_c.mant};
   assign man_b_c = {1'b1, op_b_c.mant};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr     <= '0;
         credits <= CRD_W'(FIFO_DEPTH);
      end else begin
         if (issue_c) begin
            ptr <= (gidx_c == ID_W'(NUM_REQ - 1)) ? '0 : gidx_c + ID_W'(1);
         end
         if (issue_c && !pop_c) begin
            credits <= credits - CRD_W'(1);
         end else if (!issue_c && pop_c) begin
            credits <= credits + CRD_W'(1);
         end
      end
   end

   // S1 multiply and S2 normalize
   logic                 s1_valid;
   logic [ID_W-1:0]      s1_id;
   logic                 s1_sign;
   logic [EXP_W-1:0]     s1_esum;
   logic [PROD_HI_W-1:0] s1_mhi;
   logic                 s2_valid;
   logic [ID_W-1:0]      s2_id;
   fp16_t                s2_res;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s2_valid <= 1'b0;
      end else begin
         s1_valid <= issue_c;
         s2_valid <= s1_valid;
      end
   end

   always_ff @(posedge clk) begin
      if (issue_c) begin
         s1_id   <= gidx_c;
         s1_sign <= op_a_c.sign ^ op_b_c.sign;
         s1_esum <= op_a_c.expo + op_b_c.expo - EXP_W'(BIAS);
         s1_mhi  <= PROD_HI_W'((PROD_W'(man_a_c) * PROD_W'(man_b_c)) >> MAN_W);
      end
      if (s1_valid) begin
         s2_id  <= s1_id;
         s2_res <= fp16_norm(s1_sign, s1_esum, s1_mhi);
      end
   end

   // Result FIFO; head_valid mirrors count != 0 as a register.
   logic [ENT_W-1:0] fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CRD_W-1:0] count;
   logic [CRD_W-1:0] count_next_c;
   logic             head_valid;

   assign push_c = s2_valid;
   assign pop_c  = head_valid & bus.rsp_ready;

   always_comb begin
      count_next_c = count;
      if (push_c && !pop_c) begin
         count_next_c = count + CRD_W'(1);
      end else if (!push_c && pop_c) begin
         count_next_c = count - CRD_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push_c) begin
         fifo_mem[wr_ptr] <= {s2_id, s2_res};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         head_valid <= 1'b0;
      end else begin
         if (push_c) begin
            wr_ptr <= (wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
         end
         if (pop_c) begin
            rd_ptr <= (rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
         end
         count      <= count_next_c;
         head_valid <= (count_next_c != '0);
      end
   end

   assign bus.rsp_valid               = head_valid;
   assign {bus.rsp_id, bus.rsp_data}  = fifo_mem[rd_ptr];

`ifdef MUL_ARB_STALL_CNT_EN
   // Counts cycles where some requester waits only because credits ran out.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stall_cnt <= '0;
      end else if ((|bus.req_valid) && (credits == '0) && (stall_cnt != 16'hFFFF)) begin
         stall_cnt <= stall_cnt + 16'd1;
      end
   end
`endif

endmodule
